spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Receive-side counterpart to the neuron spike output. Converts a level-type spike train back into numeric values.
- Detects rising edges of spike_in.
- Counts edges over a programmable window of clock cycles.
- Measures the inter-spike interval (ISI).
- Delivers each window's result over a valid/ready handshake.
The 9-bit rate result can drive a downstream neuron's current input, or be read by host logic.

Parameters:
WINDOW_W, 16, width of window_len and of the window cycle counter
COUNT_W, 9, width of rate_out; edge count saturates at 2^COUNT_W-1
ISI_W, 16, width of isi_out; ISI counter saturates at 2^ISI_W-1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run windows while high
spike_in  in  1  level spike from neuron; rising edge = one spike
window_len  in  WINDOW_W  window length in cycles; sampled at window start
rate_out  out  COUNT_W  rising edges in last completed window
isi_out  out  ISI_W  most recent in-window ISI; all-ones if fewer than 2 edges
result_valid  out  1  result registers hold an unconsumed result
result_ready  in  1  consumer accepts result when high with result_valid
overflow  out  1  sticky: a completed window was dropped
busy  out  1  high while state is COUNT

Behaviour:
- Reset: clock is clock; reset is reset, synchronous, active-high.
  - All outputs are 0, except isi_out = all-ones.
  - State goes to IDLE.
  - spike_prev is set to 1, so a spike already high coming out of reset is not counted.
- Edge detect:
  - edge = spike_in & ~spike_prev, evaluated every cycle.
  - spike_prev <= spike_in every cycle, in all states.
- FSM has two states: IDLE and COUNT.
  - IDLE -> COUNT when enable=1 and window_len != 0. On entry:
    - latch window_len into win_len_q;
    - clear win_cnt, edge_cnt, isi_cnt;
    - clear have_edge;
    - set isi_q to all-ones.
  - window_len == 0 keeps the block in IDLE and produces no result.
  - In COUNT, each cycle is one window cycle:
    - win_cnt increments;
    - edge_cnt increments, saturating, on edge.
  - ISI measurement:
    - isi_cnt increments, saturating, every window cycle.
    - On an edge with have_edge=1: isi_q <= isi_cnt + 1 (saturating), then isi_cnt <= 0.
    - On the first edge: have_edge <= 1 and isi_cnt <= 0.
    - Edges at window cycles 3 and 8 report ISI 5.
  - The last window cycle is win_cnt == win_len_q-1.
    - An edge in that cycle is included in the result.
    - Result publishes on the following cycle.
    - If enable=1, the next window starts back-to-back, with no gap cycle and window_len re-sampled. Otherwise go to IDLE.
  - enable=0 during COUNT aborts the window: return to IDLE next cycle, no result, no overflow.
- Result handshake:
  - Publish loads rate_out, isi_out and result_valid <= 1 when result_valid=0, or when result_ready=1 in the same cycle.
  - If result_valid=1 and result_ready=0 at publish: the new result is dropped, outputs are unchanged, and overflow <= 1.
  - Handshake without publish: result_valid=1 & result_ready=1 clears result_valid next cycle; rate_out and isi_out hold their values.
  - overflow clears only on reset.
- Reset mid-window discards all state. No partial result is emitted.
- All arithmetic is unsigned. Counters saturate and never wrap.

Optional Feature:
SPIKE_DEC_ISI_EN
- Defined: ISI counter and isi_q are built; isi_out behaves as above.
- Undefined: no ISI logic is built; isi_out is constant all-ones; all other behaviour is identical.

Decomposition:
- Shared package (spike_pkg):
  - default widths WINDOW_W, COUNT_W, ISI_W;
  - FSM state enum {IDLE, COUNT};
  - ISI_NONE constant (all-ones).
- One natural sub-module: spike_edge_detect, holding the spike_prev register (reset value 1) and producing the edge pulse. Reusable by other spike consumers.
- The result register and handshake stay in the top level.

Test Plan:
- Basic rate:
  - Stimulus: window_len=20, enable=1, result_ready=1; 3-cycle spike pulses rising at window cycles 2, 7, 15.
  - Required: rate_out=3, isi_out=8, result_valid for 1 cycle, published the cycle after window cycle 19.
- Single or no edge:
  - Stimulus: window_len=10; one edge in window 1, none in window 2.
  - Required: results (1, all-ones) then (0, all-ones).
  - Also: a spike held high across a window boundary is counted once only.
- Backpressure and overflow:
  - Stimulus: window_len=5, result_ready=0 for 3 windows.
  - Required: first result held, windows 2-3 dropped, overflow=1 from the second publish.
  - Then result_ready=1 for one cycle: result_valid=0 next cycle, overflow stays 1.
- Saturation:
  - Stimulus: COUNT_W=9, spike toggling every cycle, window_len=2000.
  - Required: rate_out=511.
- Abort and reset:
  - Stimulus: enable dropped at window cycle 4 of 10.
  - Required: busy=0 next cycle, no result_valid.
  - Stimulus: reset at window cycle 6 with spike_in=1.
  - Required: outputs at reset values; the held-high spike is not counted after reset is released.
- Zero length and macro:
  - Stimulus: window_len=0 with enable=1.
  - Required: stays IDLE, busy=0.
  - Stimulus: build without SPIKE_DEC_ISI_EN.
  - Required: isi_out is all-ones on every result.

Source files
------------

// File: rtl/spike_pkg.sv
// spike_pkg: shared widths, FSM state encoding and the "no ISI" marker for
// the spike-train receive path.
package spike_pkg;

  localparam int WINDOW_W_DEF = 16;
  localparam int COUNT_W_DEF  = 9;
  localparam int ISI_W_DEF    = 16;

  // Reported on isi_out whenever no interval has been measured.
  localparam logic [ISI_W_DEF-1:0] ISI_NONE = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } spk_state_e;

endpackage

// File: rtl/spike_edge_detect.sv
// spike_edge_detect: one-cycle pulse on each rising edge of a level spike.
// The previous-level register resets to 1, so a spike that is already high
// when reset is released does not produce a pulse.
module spike_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_spike,
  output logic o_edge
);

  logic r_spike_prev;

  // Track the previous spike level every cycle, regardless of decoder state.
  always_ff @(posedge clock) begin
    if (reset) r_spike_prev <= 1'b1;
    else       r_spike_prev <= i_spike;
  end

  assign o_edge = i_spike & ~r_spike_prev;

endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spike rising edges over a programmable window,
// measures the latest in-window inter-spike interval, and hands each window's
// result out over a valid/ready handshake.
// Build option: SPIKE_DEC_ISI_EN builds the ISI measurement; without it
// isi_out is tied to all-ones.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int WINDOW_W = WINDOW_W_DEF,
  parameter int COUNT_W  = COUNT_W_DEF,
  parameter int ISI_W    = ISI_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                spike_in,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [COUNT_W-1:0]  rate_out,
  output logic [ISI_W-1:0]    isi_out,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                overflow,
  output logic                busy
);

  spk_state_e          r_state, w_state_nxt;
  logic [WINDOW_W-1:0] r_win_len;
  logic [WINDOW_W-1:0] r_win_cnt;
  logic [COUNT_W-1:0]  r_edge_cnt;
  logic [COUNT_W-1:0]  w_edge_cnt_nxt;
  logic [COUNT_W-1:0]  r_rate_out;
  logic                r_result_valid;
  logic                r_overflow;
  logic                w_edge;
  logic                w_start;
  logic                w_last;
  logic                w_load;
  logic                w_publish;
  logic [ISI_W-1:0]    w_isi_result;

  spike_edge_detect u_edge (
    .clock   (clock),
    .reset   (reset),
    .i_spike (spike_in),
    .o_edge  (w_edge)
  );

  assign w_start = enable && (window_len != '0);
  assign w_last  = (r_state == COUNT) && (r_win_cnt == (r_win_len - WINDOW_W'(1)));

  // Edge count including an edge in the current cycle; saturates.
  assign w_edge_cnt_nxt = (w_edge && (r_edge_cnt != '1)) ? r_edge_cnt + COUNT_W'(1)
                                                          : r_edge_cnt;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, window (re)load and publish strobes. The last window cycle
  // always publishes; a new window follows back-to-back only if still enabled.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_publish   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = COUNT;
          w_load      = 1'b1;
        end
      end
      COUNT: begin
        if (w_last) begin
          w_publish = 1'b1;
          if (w_start) begin
            w_state_nxt = COUNT;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (!enable) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Window length latch, window cycle counter and edge counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_win_len  <= '0;
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
    end else if (w_load) begin
      r_win_len  <= window_len;
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
    end else if (r_state == COUNT) begin
      r_win_cnt  <= r_win_cnt + WINDOW_W'(1);
      r_edge_cnt <= w_edge_cnt_nxt;
    end
  end

`ifdef SPIKE_DEC_ISI_EN
  logic [ISI_W-1:0] r_isi_cnt;
  logic [ISI_W-1:0] r_isi_q;
  logic             r_have_edge;
  logic [ISI_W-1:0] w_isi_inc;

  // Interval counter is one behind the edge cycle, so the interval is cnt+1.
  assign w_isi_inc    = (r_isi_cnt != '1) ? r_isi_cnt + ISI_W'(1) : r_isi_cnt;
  assign w_isi_result = (w_edge && r_have_edge) ? w_isi_inc : r_isi_q;

  // Interval measurement: restart on every edge, capture from the second on.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_isi_cnt   <= '0;
      r_isi_q     <= '1;
      r_have_edge <= 1'b0;
    end else if (w_load) begin
      r_isi_cnt   <= '0;
      r_isi_q     <= '1;
      r_have_edge <= 1'b0;
    end else if (r_state == COUNT) begin
      r_isi_q     <= w_isi_result;
      r_isi_cnt   <= w_edge ? '0 : w_isi_inc;
      if (w_edge) r_have_edge <= 1'b1;
    end
  end
`else
  assign w_isi_result = '1;
`endif

  // Result registers and handshake; a publish into a held result is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rate_out     <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
    end else if (w_publish) begin
      if (!r_result_valid || result_ready) begin
        r_rate_out     <= w_edge_cnt_nxt;
        r_result_valid <= 1'b1;
      end else begin
        r_overflow     <= 1'b1;
      end
    end else if (r_result_valid && result_ready) begin
      r_result_valid <= 1'b0;
    end
  end

`ifdef SPIKE_DEC_ISI_EN
  logic [ISI_W-1:0] r_isi_out;

  // ISI output follows the same load condition as rate_out.
  always_ff @(posedge clock) begin
    if (reset)
      r_isi_out <= '1;
    else if (w_publish && (!r_result_valid || result_ready))
      r_isi_out <= w_isi_result;
  end

  assign isi_out = r_isi_out;
`else
  assign isi_out = w_isi_result;
`endif

  assign rate_out     = r_rate_out;
  assign result_valid = r_result_valid;
  assign overflow     = r_overflow;
  assign busy         = (r_state == COUNT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder. Window cycle k runs between clock
// edges k+1 and k+2 after enable is raised; a result is visible just after
// the edge that ends the last window cycle.
module tb_spike_rate_decoder;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        spike_in;
  logic [15:0] window_len;
  logic [8:0]  rate_out;
  logic [15:0] isi_out;
  logic        result_valid;
  logic        result_ready;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad   = 0;

  spike_rate_decoder dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .spike_in     (spike_in),
    .window_len   (window_len),
    .rate_out     (rate_out),
    .isi_out      (isi_out),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .overflow     (overflow),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic pat1(input int wc);
    return (wc >= 2 && wc <= 4) || (wc >= 7 && wc <= 9) || (wc >= 15 && wc <= 17);
  endfunction

  function automatic logic pat2(input int wabs);
    int w, wc;
    w  = wabs / 10;
    wc = wabs % 10;
    if (wabs < 0) return 1'b0;
    return (w == 0 && (wc == 3 || wc == 4)) || (w == 2 && wc >= 8) || (w == 3 && wc <= 2);
  endfunction

  logic [31:0] isi_exp1, isi_exp4;
  int          rate_exp2 [4] = '{1, 0, 1, 0};
  int          seen_valid;

  initial begin
`ifdef SPIKE_DEC_ISI_EN
    isi_exp1 = 32'd8;
    isi_exp4 = 32'd2;
`else
    isi_exp1 = 32'hFFFF;
    isi_exp4 = 32'hFFFF;
`endif
    reset = 1'b1; enable = 1'b0; spike_in = 1'b0; window_len = '0; result_ready = 1'b1;
    tick(); tick();
    chk("rst_rate",  rate_out,     0);
    chk("rst_isi",   isi_out,      32'hFFFF);
    chk("rst_valid", result_valid, 0);
    chk("rst_ovf",   overflow,     0);
    chk("rst_busy",  busy,         0);
    reset = 1'b0;
    tick();

    // Basic rate: edges at window cycles 2, 7, 15 of a 20-cycle window.
    enable = 1'b1; window_len = 16'd20;
    for (int i = 0; i <= 21; i++) begin
      spike_in = pat1(i - 1);
      tick();
      if (i == 10) chk("b_busy", busy, 1);
      if (i == 19) chk("b_valid_early", result_valid, 0);
      if (i == 20) begin
        chk("b_valid", result_valid, 1);
        chk("b_rate",  rate_out,     3);
        chk("b_isi",   isi_out,      isi_exp1);
      end
      if (i == 21) chk("b_valid_1cyc", result_valid, 0);
    end
    spike_in = 1'b0; enable = 1'b0;
    tick();
    chk("b_abort_busy", busy, 0);

    // Single edge, no edge, and a spike held across a window boundary.
    enable = 1'b1; window_len = 16'd10;
    for (int i = 0; i <= 40; i++) begin
      spike_in = pat2(i - 1);
      tick();
      if (i >= 10 && ((i + 1) % 10 == 1)) begin
        chk("s_valid", result_valid, 1);
        chk("s_rate",  rate_out,     rate_exp2[(i + 1) / 10 - 1]);
        chk("s_isi",   isi_out,      32'hFFFF);
      end
    end
    spike_in = 1'b0; enable = 1'b0;
    tick();

    // Backpressure: first result held, next two dropped with overflow.
    result_ready = 1'b0; enable = 1'b1; window_len = 16'd5;
    for (int i = 0; i <= 15; i++) begin
      spike_in = (i - 1 == 1);
      tick();
      if (i == 5 || i == 10 || i == 15) begin
        chk("o_valid", result_valid, 1);
        chk("o_rate",  rate_out,     1);
        chk("o_ovf",   overflow,     (i == 5) ? 0 : 1);
      end
    end
    enable = 1'b0; result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("o_drain_valid", result_valid, 0);
    chk("o_drain_ovf",   overflow,     1);
    chk("o_drain_rate",  rate_out,     1);
    result_ready = 1'b1;

    // Saturation: spike toggles every cycle over a 2000-cycle window.
    enable = 1'b1; window_len = 16'd2000;
    for (int i = 0; i <= 2000; i++) begin
      spike_in = i[0];
      tick();
    end
    chk("sat_valid", result_valid, 1);
    chk("sat_rate",  rate_out,     511);
    chk("sat_isi",   isi_out,      isi_exp4);
    spike_in = 1'b0; enable = 1'b0;
    tick();
    tick();

    // Abort at window cycle 4 of 10.
    enable = 1'b1; window_len = 16'd10;
    for (int i = 0; i < 5; i++) tick();
    chk("a_busy_before", busy, 1);
    enable = 1'b0;
    tick();
    chk("a_busy_after", busy, 0);
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (result_valid) seen_valid++;
    end
    chk("a_no_result", seen_valid, 0);

    // Reset at window cycle 6 with the spike held high.
    enable = 1'b1; window_len = 16'd10;
    for (int i = 0; i < 7; i++) begin
      spike_in = (i - 1 >= 3);
      tick();
    end
    reset = 1'b1;
    tick();
    chk("r_rate",  rate_out,     0);
    chk("r_isi",   isi_out,      32'hFFFF);
    chk("r_valid", result_valid, 0);
    chk("r_ovf",   overflow,     0);
    chk("r_busy",  busy,         0);
    reset = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("r_post_valid", result_valid, 1);
    chk("r_post_rate",  rate_out,     0);
    enable = 1'b0; spike_in = 1'b0;
    tick();
    tick();

    // Zero window length never starts.
    enable = 1'b1; window_len = 16'd0;
    tick(); tick(); tick();
    chk("z_busy",  busy,         0);
    chk("z_valid", result_valid, 0);
    enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
